// File: rtl/icache_ctrl_pkg.sv
// Shared constants, FSM state type and address-field helpers for the icache control stage.
package icache_ctrl_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] AR_LEN_2B  = 8'd1;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFS_LEN = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_AR     = 3'd2,
    S_R      = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] word);
    word_sel = line[32*word +: 32];
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Instruction cache control stage: tag compare, hit return, 2-beat AXI4 line refill.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 6,
  parameter int TAG_LEN  = DATA_LEN - ADDR_LEN - 4,
  parameter int AXI_DW   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_err,
  output logic [TAG_LEN-1:0]  line_tag_in,
  input  logic                line_valid,
  input  logic [TAG_LEN-1:0]  line_tag,
  input  logic [127:0]        line_Q,
  output logic                line_CEN,
  output logic                line_WEN,
  output logic [127:0]        line_BWEN,
  output logic [ADDR_LEN-1:0] line_A,
  output logic [127:0]        line_D,
  output logic                arvalid,
  input  logic                arready,
  output logic [DATA_LEN-1:0] araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [AXI_DW-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  state_e              state_q, state_d;
  logic [DATA_LEN-1:2] addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [127:0]        buf_q, buf_d;
  logic                err_q, err_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                rerr_q, rerr_d;

  logic [TAG_LEN-1:0]  lat_tag;
  logic [ADDR_LEN-1:0] lat_idx;
  logic [1:0]          lat_word;
  logic                hit;
  logic                beat_err;
  logic                unused_addr_lsb;

  assign lat_tag  = addr_q[DATA_LEN-1 -: TAG_LEN];
  assign lat_idx  = addr_q[OFFS_LEN +: ADDR_LEN];
  assign lat_word = addr_q[3:2];
  assign unused_addr_lsb = ^req_addr[1:0];

  assign hit = line_valid && (line_tag == lat_tag);
  // A non-OKAY beat, an rlast on the first beat, or a beat past the second all poison the refill.
  assign beat_err = (rresp != RESP_OKAY) || (rlast && (cnt_q == 2'd0)) || cnt_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      data_q  <= data_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_RESP : S_AR;
      S_AR:     if (arready) state_d = S_R;
      S_R:      if (rvalid && rlast) state_d = (err_q || beat_err) ? S_RESP : S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    err_d  = err_q;
    data_d = data_q;
    rerr_d = rerr_q;
    case (state_q)
      S_IDLE:   if (req_valid) addr_d = req_addr[DATA_LEN-1:2];
      S_LOOKUP: if (hit) begin
        data_d = word_sel(line_Q, lat_word);
        rerr_d = 1'b0;
      end
      S_AR:     if (arready) cnt_d = '0;
      S_R:      if (rvalid) begin
        if (!cnt_q[1]) begin
          if (cnt_q[0]) buf_d[127:64] = rdata;
          else          buf_d[63:0]   = rdata;
          cnt_d = cnt_q + 2'd1;
        end
        err_d = err_q | beat_err;
        if (rlast && (err_q || beat_err)) begin
          data_d = '0;
          rerr_d = 1'b1;
        end
      end
      S_WRITE: begin
        data_d = word_sel(buf_q, lat_word);
        rerr_d = 1'b0;
      end
      S_RESP:   if (resp_ready) err_d = 1'b0;
      default: ;
    endcase
  end

  // req_ready and the accept-time SRAM read are gated by rst_n so reset holds them quiet.
  always_comb begin
    req_ready = 1'b0;
    line_CEN  = 1'b1;
    line_WEN  = 1'b1;
    line_BWEN = '1;
    line_A    = lat_idx;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst_n;
        line_A    = req_addr[OFFS_LEN +: ADDR_LEN];
        if (req_valid && rst_n) line_CEN = 1'b0;
      end
      S_AR:    arvalid = 1'b1;
      S_R:     rready  = 1'b1;
      S_WRITE: begin
        line_CEN  = 1'b0;
        line_WEN  = 1'b0;
        line_BWEN = '0;
      end
      default: ;
    endcase
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = data_q;
  assign resp_err    = rerr_q;
  assign line_D      = buf_q;
  assign line_tag_in = lat_tag;
  assign araddr      = {lat_tag, lat_idx, 4'b0000};
  assign arlen       = AR_LEN_2B;
  assign arsize      = SIZE_8B;
  assign arburst     = BURST_INCR;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: SRAM/tag array and AXI memory models plus a line-level reference cache.
module tb_icache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic [21:0]  line_tag_in;
  logic         line_valid;
  logic [21:0]  line_tag;
  logic [127:0] line_Q;
  logic         line_CEN;
  logic         line_WEN;
  logic [127:0] line_BWEN;
  logic [5:0]   line_A;
  logic [127:0] line_D;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  icache_ctrl #(.DATA_LEN(32), .ADDR_LEN(6), .TAG_LEN(22), .AXI_DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .line_tag_in(line_tag_in), .line_valid(line_valid), .line_tag(line_tag), .line_Q(line_Q),
    .line_CEN(line_CEN), .line_WEN(line_WEN), .line_BWEN(line_BWEN), .line_A(line_A), .line_D(line_D),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag/valid/data array sitting behind the controller: one-cycle registered read.
  bit         a_valid [64];
  bit [21:0]  a_tag   [64];
  bit [127:0] a_data  [64];
  always @(posedge clk) begin
    if (!line_CEN && line_WEN) begin
      line_valid <= a_valid[line_A];
      line_tag   <= a_tag[line_A];
      line_Q     <= a_data[line_A];
    end
    if (!line_CEN && !line_WEN) begin
      a_data[line_A]  <= (a_data[line_A] & line_BWEN) | (line_D & ~line_BWEN);
      a_tag[line_A]   <= line_tag_in;
      a_valid[line_A] <= 1'b1;
    end
  end

  // Reference: which tag each line index is known to hold.
  bit        ref_valid [64];
  bit [21:0] ref_tag   [64];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_beat(input logic [31:0] la, input int b);
    if (la == 32'h8000_0010) return (b == 0) ? 64'h1111_2222_3333_4444 : 64'h5555_6666_7777_8888;
    return {la ^ 32'(b * 8 + 4) ^ 32'h5A5A_0000, la ^ 32'(b * 8) ^ 32'hA5A5_0000};
  endfunction

  task automatic fetch(input logic [31:0] addr, input int err_beat, input bit early,
                       input int ar_wait, input int r_gap, input int rr_wait);
    logic [21:0]  t;
    logic [5:0]   ix;
    logic [1:0]   w;
    logic [31:0]  la;
    logic [127:0] line;
    logic [31:0]  exp_data;
    logic [31:0]  first_araddr;
    logic [5:0]   wr_a;
    logic [21:0]  wr_tag;
    bit           hit, will_err, ar_bad, wr_bad, busy_bad, hold_bad;
    int           n, ar_n, beats, gap, writes, arcount;
    t = addr[31:10]; ix = addr[9:4]; w = addr[3:2];
    la = {addr[31:4], 4'b0000};
    line = {mem_beat(la, 1), mem_beat(la, 0)};
    hit = ref_valid[ix] && (ref_tag[ix] == t);
    will_err = !hit && (err_beat != 0 || early);
    exp_data = will_err ? 32'h0 : line[32*w +: 32];
    ar_bad = 0; wr_bad = 0; busy_bad = 0; hold_bad = 0;
    n = 1; ar_n = 0; beats = 0; gap = 0; writes = 0; arcount = 0;
    first_araddr = '0; wr_a = '0; wr_tag = '0;

    req_valid = 1'b1;
    req_addr  = addr;
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    while (!resp_valid && n < 400) begin
      arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = {$urandom, $urandom};
      if (req_ready) busy_bad = 1;
      if (arvalid) begin
        arcount++;
        if (arcount == 1) first_araddr = araddr;
        else if (araddr !== first_araddr) ar_bad = 1;
        if (arlen !== 8'd1 || arsize !== 3'b011 || arburst !== 2'b01) ar_bad = 1;
        if (ar_n >= ar_wait) arready = 1;
        else ar_n++;
      end else if (rready) begin
        if (gap < r_gap) gap++;
        else begin
          gap = 0;
          rvalid = 1;
          rdata = mem_beat(la, beats);
          rresp = (err_beat == beats + 1) ? 2'b10 : 2'b00;
          rlast = early || (beats == 1);
          beats++;
        end
      end
      if (!line_CEN && !line_WEN) begin
        writes++;
        wr_a = line_A;
        wr_tag = line_tag_in;
        if (line_BWEN !== '0) wr_bad = 1;
      end
      tick();
      n++;
    end
    arready = 0; rvalid = 0; rlast = 0; rresp = 0;

    chk("resp_timeout", 128'(resp_valid), 128'(1));
    chk("resp_data", 128'(resp_data), 128'(exp_data));
    chk("resp_err", 128'(resp_err), 128'(will_err));
    chk("req_ready_busy", 128'(busy_bad), 128'(0));
    chk("ar_issued", 128'(arcount != 0), 128'(!hit));
    chk("write_count", 128'(writes), 128'((!hit && !will_err) ? 1 : 0));
    if (hit) chk("hit_latency", 128'(n), 128'(2));
    if (arcount != 0) begin
      chk("araddr", 128'(first_araddr), 128'(la));
      chk("ar_stable", 128'(ar_bad), 128'(0));
    end
    if (writes != 0) begin
      chk("write_index", 128'(wr_a), 128'(ix));
      chk("write_tag", 128'(wr_tag), 128'(t));
      chk("write_bwen", 128'(wr_bad), 128'(0));
    end

    for (int i = 0; i < rr_wait; i++) begin
      tick();
      if (!resp_valid || resp_data !== exp_data || resp_err !== will_err || req_ready) hold_bad = 1;
    end
    if (rr_wait > 0) chk("resp_hold", 128'(hold_bad), 128'(0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_release", 128'(resp_valid), 128'(0));

    if (!hit && !will_err) begin
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = t;
    end
  endtask

  initial begin
    int e, n;
    logic [31:0] a;
    req_valid = 0; req_addr = '0; resp_ready = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_err", 128'(resp_err), 128'(0));
    chk("rst_arvalid", 128'(arvalid), 128'(0));
    chk("rst_cen", 128'(line_CEN), 128'(1));
    chk("rst_bwen", line_BWEN, {128{1'b1}});
    #20 rst_n = 1'b1;
    tick();

    // Directed: cold miss, hit, conflict, re-miss, error beats, stalls.
    fetch(32'h8000_0014, 0, 0, 0, 0, 0);
    fetch(32'h8000_0018, 0, 0, 0, 0, 0);
    fetch(32'h8000_0414, 0, 0, 0, 0, 0);
    fetch(32'h8000_0418, 0, 0, 0, 0, 0);
    fetch(32'h8000_0014, 0, 0, 0, 0, 0);
    fetch(32'h8000_0024, 2, 0, 0, 0, 0);
    fetch(32'h8000_0024, 0, 0, 0, 0, 0);
    fetch(32'h8000_0034, 0, 1, 0, 0, 0);
    fetch(32'h8000_0034, 0, 0, 0, 0, 0);
    fetch(32'h8000_0040, 0, 0, 5, 2, 3);
    fetch(32'h8000_004C, 0, 0, 0, 0, 3);

    // Asynchronous reset while mid-burst, one beat already buffered.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0854;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("rst_reach_ar", 128'(arvalid), 128'(1));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D; rresp = 2'b00; rlast = 1'b0;
    tick();
    rvalid = 1'b0;
    chk("rst_in_r", 128'(rready), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 128'(req_ready), 128'(0));
    chk("arst_rready", 128'(rready), 128'(0));
    chk("arst_resp_valid", 128'(resp_valid), 128'(0));
    chk("arst_arvalid", 128'(arvalid), 128'(0));
    chk("arst_cen_wen", 128'({line_CEN, line_WEN}), 128'(2'b11));
    chk("arst_buffer", line_D, 128'(0));
    #3 rst_n = 1'b1;
    tick();
    fetch(32'h8000_0854, 0, 0, 1, 1, 1);
    fetch(32'h8000_0858, 0, 0, 0, 0, 0);

    // Random traffic over a few indices and tags so hits, conflicts and errors mix.
    for (int k = 0; k < 60; k++) begin
      a = {10'b1000_0000_00, 12'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      e = int'($urandom_range(0, 9));
      fetch(a, (e == 0) ? 1 : (e == 1) ? 2 : 0, e == 2,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
